// File: rtl/la_pkg.sv
// Shared types and constants for the logic-analyser capture/dump blocks.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package la_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RD,
        LATCH,
        WAIT
    } dump_state_t;

    localparam logic [2:0] CH_MIN = 3'd1;
    localparam logic [2:0] CH_MAX = 3'd5;

    // A channel number names one of the sample RAMs only inside CH_MIN..CH_MAX.
    function automatic logic chan_valid(input logic [2:0] ch);
        return (ch >= CH_MIN) && (ch <= CH_MAX);
    endfunction

endpackage

// File: rtl/dump_ctrl_if.sv
// Dump command, RAM read port and UART response signals of dump_ctrl.
// Latency: none (wiring only).
// Backpressure: resp_sent from the transmitter paces every send_resp.
interface dump_ctrl_if #(
    parameter int LOG2 = 9
);

    logic            dump_start;
    logic [2:0]      dump_chan;
    logic [LOG2-1:0] addr_ptr;
    logic [7:0]      rdataCH1;
    logic [7:0]      rdataCH2;
    logic [7:0]      rdataCH3;
    logic [7:0]      rdataCH4;
    logic [7:0]      rdataCH5;
    logic            resp_sent;

    logic [LOG2-1:0] raddr;
    logic [7:0]      resp;
    logic            send_resp;
    logic            dump_busy;
    logic            dump_done;
    logic            dump_err;

    // Environment side: command decoder, sample RAMs and UART transmitter.
    modport master (
        output dump_start, dump_chan, addr_ptr,
        output rdataCH1, rdataCH2, rdataCH3, rdataCH4, rdataCH5,
        output resp_sent,
        input  raddr, resp, send_resp, dump_busy, dump_done, dump_err
    );

    // Dump sequencer side.
    modport slave (
        input  dump_start, dump_chan, addr_ptr,
        input  rdataCH1, rdataCH2, rdataCH3, rdataCH4, rdataCH5,
        input  resp_sent,
        output raddr, resp, send_resp, dump_busy, dump_done, dump_err
    );

endinterface

// File: rtl/wrap_ptr.sv
// Circular buffer address register: load, increment, wrap from ENTRIES-1 to 0.
// Latency: 1 clk from load/inc to the new ptr value.
// Backpressure: none; holds its value whenever neither load nor inc is set.
module wrap_ptr #(
    parameter int ENTRIES = 384,
    parameter int LOG2    = 9
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            load,
    input  logic [LOG2-1:0] load_val,
    input  logic            inc,
    output logic [LOG2-1:0] ptr
);

    localparam logic [LOG2-1:0] LAST    = LOG2'(ENTRIES - 1);
    // One bit wider so ENTRIES == 2**LOG2 still compares correctly.
    localparam logic [LOG2:0]   EXT_ENT = (LOG2 + 1)'(ENTRIES);

    // Out-of-range load values fall back to location 0; load wins over inc.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (load) begin
            ptr <= ({1'b0, load_val} < EXT_ENT) ? load_val : '0;
        end else if (inc) begin
            ptr <= (ptr == LAST) ? '0 : ptr + LOG2'(1);
        end
    end

endmodule

// File: rtl/dump_ctrl.sv
// Walks one channel's circular sample RAM from the oldest entry and hands each byte to the UART.
// Latency: dump_start at E0 -> raddr after E0, first resp/send_resp after E2; 3 clk minimum per byte.
// Backpressure: each byte is held in WAIT until resp_sent; dump_start is ignored while busy.
module dump_ctrl
    import la_pkg::*;
#(
    parameter int ENTRIES = 384,
    parameter int LOG2    = 9
) (
    input  logic        clk,
    input  logic        rst_n,
    dump_ctrl_if.slave  bus
);

    localparam logic [LOG2-1:0] LAST = LOG2'(ENTRIES - 1);

    dump_state_t     state_q;
    dump_state_t     state_d;
    logic [2:0]      chan_q;
    logic [LOG2-1:0] count_q;
    logic [7:0]      resp_q;
    logic [7:0]      sel_dat;
    logic            send_q;
    logic            busy_q;
    logic            done_q;
    logic            err_q;

    logic            accept;
    logic            reject;
    logic            ack;
    logic            last_ack;
    logic            adv;

    // Requests are only looked at in IDLE, which is what makes them ignored while busy.
    assign accept   = (state_q == IDLE) && bus.dump_start &&  chan_valid(bus.dump_chan);
    assign reject   = (state_q == IDLE) && bus.dump_start && !chan_valid(bus.dump_chan);
    assign ack      = (state_q == WAIT) && bus.resp_sent;
    assign last_ack = ack && (count_q == LAST);
    assign adv      = ack && (count_q != LAST);

    wrap_ptr #(
        .ENTRIES (ENTRIES),
        .LOG2    (LOG2)
    ) u_raddr (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (accept),
        .load_val (bus.addr_ptr),
        .inc      (adv),
        .ptr      (bus.raddr)
    );

    // Sequencer state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: one RAM read, one latch, then wait for the UART per byte.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (accept) state_d = RD;
            RD:      state_d = LATCH;
            LATCH:   state_d = WAIT;
            WAIT:    if (bus.resp_sent) state_d = (count_q == LAST) ? IDLE : RD;
            default: state_d = IDLE;
        endcase
    end

    // Channel select feeding the resp register; the channel is frozen at acceptance.
    always_comb begin
        sel_dat = 8'h00;
        unique case (chan_q)
            3'd1:    sel_dat = bus.rdataCH1;
            3'd2:    sel_dat = bus.rdataCH2;
            3'd3:    sel_dat = bus.rdataCH3;
            3'd4:    sel_dat = bus.rdataCH4;
            3'd5:    sel_dat = bus.rdataCH5;
            default: sel_dat = 8'h00;
        endcase
    end

    // Registered outputs, channel latch and byte counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chan_q  <= '0;
            count_q <= '0;
            resp_q  <= '0;
            send_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            send_q <= (state_q == LATCH);
            done_q <= last_ack;
            err_q  <= reject;
            if (state_q == LATCH) begin
                resp_q <= sel_dat;
            end
            if (accept) begin
                chan_q  <= bus.dump_chan;
                count_q <= '0;
                busy_q  <= 1'b1;
            end else begin
                if (adv) begin
                    count_q <= count_q + LOG2'(1);
                end
                if (last_ack) begin
                    busy_q <= 1'b0;
                end
            end
        end
    end

    assign bus.resp      = resp_q;
    assign bus.send_resp = send_q;
    assign bus.dump_busy = busy_q;
    assign bus.dump_done = done_q;
    assign bus.dump_err  = err_q;

endmodule
